// File: rtl/mcu_block_scheduler_if.sv
// mcu_block_scheduler_if: source/decoder/downstream handshake and block tag bundle.
interface mcu_block_scheduler_if #(parameter int NUM_CH = 3);
    localparam int CW = $clog2(NUM_CH + 1);
    logic          src_valid;
    logic          src_ready;
    logic          dec_request;
    logic          dec_valid_in;
    logic          dec_valid;
    logic [CW-1:0] dec_ch;
    logic          ds_free;
    logic          blk_valid;
    logic [CW-1:0] blk_comp;
    logic [1:0]    blk_idx;
    logic          blk_mcu_last;
    modport master (
        input  src_valid, dec_request, dec_valid, dec_ch, ds_free,
        output src_ready, dec_valid_in, blk_valid, blk_comp, blk_idx, blk_mcu_last
    );
    modport slave (
        output src_valid, dec_request, dec_valid, dec_ch, ds_free,
        input  src_ready, dec_valid_in, blk_valid, blk_comp, blk_idx, blk_mcu_last
    );
endinterface

// File: rtl/mcu_block_scheduler.sv
// mcu_block_scheduler: sequences entropy decoding over a frame with credit flow control and block tagging.
// Optional RESTART_EN macro adds restart_interval input and dc_pred_clr output.
module mcu_block_scheduler #(
    parameter int NUM_CH  = 3,
    parameter int CREDITS = 2,
    parameter int MCU_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MCU_W-1:0] num_mcus,
    input  logic [2:0]       y_blocks,
`ifdef RESTART_EN
    input  logic [MCU_W-1:0] restart_interval,
    output logic             dc_pred_clr,
`endif
    output logic [MCU_W-1:0] mcu_count,
    output logic             busy,
    output logic             done,
    output logic             seq_err,
    mcu_block_scheduler_if.master bus
);
    localparam int CW = $clog2(NUM_CH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state;
    logic [2:0]       credits;
    logic [CW-1:0]    comp;
    logic [1:0]       idx, ylast;
    logic [MCU_W-1:0] nm;
    logic             clr, feed, dv, comp_end, mlast, flast, under, over;
    assign feed     = bus.src_valid && bus.dec_request && state == RUN && credits != 0 && !clr;
    assign bus.dec_valid_in = feed;
    assign bus.src_ready    = feed;
    assign dv       = bus.dec_valid && state == RUN;
    assign comp_end = comp != 0 || idx == ylast;
    assign mlast    = comp_end && comp == CW'(NUM_CH - 1);
    assign flast    = mlast && mcu_count == nm - 1'b1;
    assign under    = dv && !bus.ds_free && credits == 0;
    assign over     = bus.ds_free && !dv && credits == 3'(CREDITS);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            credits          <= 3'(CREDITS);
            comp             <= '0;
            idx              <= '0;
            ylast            <= '0;
            nm               <= '0;
            mcu_count        <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            seq_err          <= 1'b0;
            bus.blk_valid    <= 1'b0;
            bus.blk_comp     <= '0;
            bus.blk_idx      <= '0;
            bus.blk_mcu_last <= 1'b0;
        end else begin
            bus.blk_valid <= 1'b0;
            if (bus.ds_free && !dv && !over)
                credits <= credits + 3'd1;
            else if (dv && !bus.ds_free && !under)
                credits <= credits - 3'd1;
            if (under || over || (bus.dec_valid && state != RUN) || (dv && bus.dec_ch != comp))
                seq_err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    nm        <= num_mcus == 0 ? MCU_W'(1) : num_mcus;
                    ylast     <= y_blocks == 3'd2 ? 2'd1 : y_blocks == 3'd4 ? 2'd3 : 2'd0;
                    comp      <= '0;
                    idx       <= '0;
                    mcu_count <= '0;
                    seq_err   <= 1'b0;
                    credits   <= 3'(CREDITS);
                end
                RUN: if (dv) begin
                    bus.blk_valid    <= 1'b1;
                    bus.blk_comp     <= comp;
                    bus.blk_idx      <= idx;
                    bus.blk_mcu_last <= mlast;
                    idx              <= comp_end ? 2'd0 : idx + 2'd1;
                    comp             <= mlast ? '0 : comp_end ? comp + 1'b1 : comp;
                    if (mlast) mcu_count <= mcu_count + 1'b1;
                    if (flast) state <= DRAIN;
                end
                DRAIN: if (credits == 3'(CREDITS)) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`ifdef RESTART_EN
    logic [MCU_W-1:0] ri, rcnt;
    assign dc_pred_clr = clr;
    // clr doubles as a one-cycle feed blank so the decoder resets DC prediction before the next MCU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ri   <= '0;
            rcnt <= '0;
            clr  <= 1'b0;
        end else begin
            clr <= 1'b0;
            if (state == IDLE && start) begin
                ri   <= restart_interval;
                rcnt <= '0;
            end else if (dv && mlast) begin
                if (ri != 0 && !flast && rcnt + 1'b1 == ri) begin
                    clr  <= 1'b1;
                    rcnt <= '0;
                end else
                    rcnt <= rcnt + 1'b1;
            end
        end
    end
`else
    assign clr = 1'b0;
`endif
endmodule

// File: tb/tb_mcu_block_scheduler.sv
// tb_mcu_block_scheduler: directed self-checking bench for mcu_block_scheduler.
module tb_mcu_block_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_mcus = '0;
    logic [2:0]  y_blocks = '0;
    logic [15:0] mcu_count;
    logic        busy, done, seq_err;
    int          n_chk = 0, n_fail = 0;
    int          e_comp[6] = '{0, 0, 0, 0, 1, 2};
    int          e_idx[6]  = '{0, 1, 2, 3, 0, 0};
`ifdef RESTART_EN
    logic [15:0] restart_interval = '0;
    logic        dc_pred_clr;
`endif
    mcu_block_scheduler_if #(.NUM_CH(3)) bus ();
    mcu_block_scheduler #(.NUM_CH(3), .CREDITS(2), .MCU_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_mcus(num_mcus), .y_blocks(y_blocks),
`ifdef RESTART_EN
        .restart_interval(restart_interval), .dc_pred_clr(dc_pred_clr),
`endif
        .mcu_count(mcu_count), .busy(busy), .done(done), .seq_err(seq_err), .bus(bus.master)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_frame(input logic [15:0] nm, input logic [2:0] yb);
        num_mcus = nm;
        y_blocks = yb;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic blk(input logic [1:0] ch);
        bus.dec_valid = 1'b1;
        bus.dec_ch = ch;
        tick();
        bus.dec_valid = 1'b0;
    endtask
    task automatic free();
        bus.ds_free = 1'b1;
        tick();
        bus.ds_free = 1'b0;
    endtask
    task automatic wait_done(input int exp);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) c++;
        end
        chk("done_count", c, exp);
        chk("idle_after_frame", busy, 0);
    endtask
    initial begin
        bus.src_valid = 1'b1;
        bus.dec_request = 1'b1;
        bus.dec_valid = 1'b0;
        bus.dec_ch = '0;
        bus.ds_free = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_blk_valid", bus.blk_valid, 0);
        chk("rst_mcu_count", mcu_count, 0);
        chk("rst_valid_in", bus.dec_valid_in, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        rst = 1'b1;
        tick();
        blk(0);
        chk("idle_dv_err", seq_err, 1);
        chk("idle_dv_no_tag", bus.blk_valid, 0);
        // two MCUs, one Y block each
        start_frame(2, 1);
        chk("t1_err_cleared", seq_err, 0);
        chk("t1_busy", busy, 1);
        chk("t1_feed", bus.dec_valid_in, 1);
        for (int i = 0; i < 6; i++) begin
            blk(2'(i % 3));
            chk("t1_blk_valid", bus.blk_valid, 1);
            chk("t1_comp", bus.blk_comp, i % 3);
            chk("t1_last", bus.blk_mcu_last, i % 3 == 2);
            chk("t1_mcu_count", mcu_count, (i + 1) / 3);
            if (i == 5) chk("t1_drain_no_feed", bus.dec_valid_in, 0);
            free();
        end
        wait_done(1);
        chk("t1_no_err", seq_err, 0);
        chk("t1_final_count", mcu_count, 2);
        // four Y blocks, one MCU
        start_frame(1, 4);
        for (int i = 0; i < 6; i++) begin
            blk(2'(e_comp[i]));
            chk("t2_comp", bus.blk_comp, e_comp[i]);
            chk("t2_idx", bus.blk_idx, e_idx[i]);
            chk("t2_last", bus.blk_mcu_last, i == 5);
            free();
        end
        wait_done(1);
        chk("t2_no_err", seq_err, 0);
        // credit exhaustion, then channel mismatch
        start_frame(2, 1);
        blk(0);
        blk(1);
        chk("t3_tag2_comp", bus.blk_comp, 1);
        chk("t3_stall_valid_in", bus.dec_valid_in, 0);
        chk("t3_stall_src_ready", bus.src_ready, 0);
        free();
        chk("t3_resume", bus.dec_valid_in, 1);
        chk("t3_resume_src_ready", bus.src_ready, 1);
        blk(2);
        free();
        chk("t3_no_err_yet", seq_err, 0);
        blk(1);
        chk("t3_mismatch_err", seq_err, 1);
        chk("t3_mismatch_comp", bus.blk_comp, 0);
        free();
        blk(1);
        free();
        blk(2);
        chk("t3_count", mcu_count, 2);
        free();
        free();
        wait_done(1);
        chk("t3_err_sticky", seq_err, 1);
        // reset mid-frame
        start_frame(2, 1);
        chk("t4_err_cleared", seq_err, 0);
        blk(0);
        free();
        blk(1);
        free();
        blk(2);
        chk("t4_count_before", mcu_count, 1);
        chk("t4_tag_before", bus.blk_valid, 1);
        rst = 1'b0;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_count", mcu_count, 0);
        chk("t4_blk_valid", bus.blk_valid, 0);
        chk("t4_blk_comp", bus.blk_comp, 0);
        chk("t4_blk_last", bus.blk_mcu_last, 0);
        chk("t4_valid_in", bus.dec_valid_in, 0);
        tick();
        rst = 1'b1;
        wait_done(0);
`ifdef RESTART_EN
        restart_interval = 16'd1;
        start_frame(3, 1);
        for (int i = 0; i < 9; i++) begin
            blk(2'(i % 3));
            chk("t5_dc_pred_clr", dc_pred_clr, i == 2 || i == 5);
            if (i == 2) chk("t5_gate_forced", bus.dec_valid_in, 0);
            free();
        end
        wait_done(1);
        chk("t5_no_err", seq_err, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
